waves_led_pwm: RTL and testbench
================================

WAVES_LED_PWM -- requirements
Module: waves_led_pwm

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 address  input  2  Avalon-MM slave register select.
REQ-004 chipselect  input  1  slave select.
REQ-005 write_n  input  1  active-low write strobe; write = chipselect & ~write_n.
REQ-006 writedata  input  32  write data.
REQ-007 readdata  output  32  read data; combinational from address, zero wait states; unused bits 0.
REQ-008 led_in  input  8  LED pattern from the upstream LED PIO out_port.
REQ-009 led_out  output  8  dimmed/faded LED drive to pins, registered.

Function
REQ-010 Register map SHALL be: 0 CTRL ([0] enable, [1] fade_en); 1 DUTY ([7:0]); 2 PRESCALE ([15:0]); 3 STATUS (read-only: [7:0] pwm_cnt, [8] fade_dir, 1=down); writes to 3 ignored.
REQ-011 Prescaler SHALL count 0..PRESCALE, asserting one-cycle tick when count==PRESCALE, then wrap to 0; PRESCALE=0 gives tick every clock.
REQ-012 A write to PRESCALE SHALL clear the prescale counter in the same cycle the new value loads.
REQ-013 pwm_cnt (8-bit) SHALL increment on tick, wrapping 255->0; period_end = tick & (pwm_cnt==255).
REQ-014 led_out SHALL register, each cycle: enable=0 -> 0; DUTY=0xFF -> led_in; else led_in & {8{pwm_cnt < DUTY}}.
REQ-015 Latency led_in -> led_out SHALL be exactly one clock.
REQ-016 While enable=0, prescale counter and pwm_cnt SHALL be held at 0.
REQ-017 Fade FSM states: IDLE, UP, DOWN; IDLE whenever fade_en=0 or enable=0.
REQ-018 IDLE->UP when fade_en=1 and enable=1; DUTY starts from its current value.
REQ-019 UP: at period_end DUTY+=1; on reaching 0xFF go DOWN. DOWN: at period_end DUTY-=1; on reaching 0x00 go UP; DUTY never wraps.
REQ-020 CPU write to DUTY in the same cycle as period_end SHALL win; FSM state unchanged.
REQ-021 Reading DUTY SHALL return the live (possibly fading) duty value.
REQ-022 Clearing fade_en SHALL freeze DUTY at its current value and return to IDLE next cycle.

Reset
REQ-023 On reset: CTRL=0, DUTY=0xFF, PRESCALE=0, prescale counter=0, pwm_cnt=0, FSM=IDLE, fade_dir=0, led_out=0.
REQ-024 Reset asserted mid-fade or mid-period SHALL override any simultaneous register write.

Structure
REQ-025 Shared package SHALL hold register address constants, CTRL bit indices, fade-state encoding, DUTY reset value 0xFF.
REQ-026 Prescaler + pwm_cnt SHALL be one sub-module waves_led_pwm_timebase (outputs tick, pwm_cnt, period_end); register file, FSM, output stage stay in top.

Verification
REQ-027 Reset, enable=1, DUTY=0xFF, led_in=0xA5 -> led_out=0xA5 one clock after led_in settles; STATUS[8]=0.
REQ-028 PRESCALE=0, DUTY=0x40, led_in=0xFF -> led_out=0xFF for 64 of every 256 clocks, 0x00 for 192.
REQ-029 PRESCALE=3 -> tick every 4 clocks; write PRESCALE=1 mid-count -> next tick exactly 2 clocks after write.
REQ-030 PRESCALE=0, DUTY=0xFD, fade_en=1 -> DUTY 0xFE, 0xFF at successive period_ends, STATUS[8]=1, then 0xFE; from DUTY=0x01 in DOWN -> 0x00 then UP, never 0xFF wrap.
REQ-031 Write DUTY=0x10 in the period_end cycle while UP -> DUTY reads 0x10, next period_end 0x11.
REQ-032 enable=0 mid-period -> led_out=0 next clock, STATUS[7:0]=0; assert reset during fade -> all REQ-023 values next clock.

Source files
------------

// File: rtl/waves_led_pwm_pkg.sv
// waves_led_pwm_pkg: register map, CTRL bit indices, fade-state encoding and reset values shared by the LED PWM block
package waves_led_pwm_pkg;
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_FADE = 1;
  localparam logic [7:0] DUTY_RST = 8'hFF;
  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } fade_state_e;
endpackage

// File: rtl/waves_led_pwm_timebase.sv
// waves_led_pwm_timebase: prescaler (0..prescale) feeding an 8-bit pwm_cnt; ports clk, reset, enable, clear, prescale in; tick, pwm_cnt, period_end out
module waves_led_pwm_timebase (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] prescale,
  output logic        tick,
  output logic [7:0]  pwm_cnt,
  output logic        period_end
);
  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  always_comb begin
    tick = enable & (presc_q == prescale);
    presc_d = (!enable || clear || tick) ? 16'd0 : presc_q + 16'd1;
    cnt_d = !enable ? 8'd0 : tick ? cnt_q + 8'd1 : cnt_q;
  end
  assign pwm_cnt    = cnt_q;
  assign period_end = tick & (cnt_q == 8'hFF);
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/waves_led_pwm.sv
// waves_led_pwm: Avalon-MM LED dimmer/fader; ports clk, reset, address/chipselect/write_n/writedata/readdata slave, led_in pattern in, led_out registered drive out
module waves_led_pwm
  import waves_led_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] prescale_q, prescale_d;
  logic [7:0]  led_q, led_d;
  fade_state_e state_q, state_d;
  logic        wr, wr_ctrl, wr_duty, wr_presc;
  logic        en, fade_on, step, fade_dir;
  logic [7:0]  duty_up, duty_dn;
  logic        tick, period_end;
  logic [7:0]  pwm_cnt;
  logic        unused_ok;
  assign unused_ok = ^{writedata[31:16], tick};
  always_comb begin
    wr         = chipselect & ~write_n;
    wr_ctrl    = wr & (address == ADDR_CTRL);
    wr_duty    = wr & (address == ADDR_DUTY);
    wr_presc   = wr & (address == ADDR_PRESCALE);
    ctrl_d     = wr_ctrl ? writedata[1:0] : ctrl_q;
    prescale_d = wr_presc ? writedata[15:0] : prescale_q;
    en         = ctrl_d[CTRL_EN];
    fade_on    = en & ctrl_d[CTRL_FADE];
    duty_up    = (duty_q == 8'hFF) ? duty_q : duty_q + 8'd1;
    duty_dn    = (duty_q == 8'h00) ? duty_q : duty_q - 8'd1;
    step       = fade_on & period_end & ~wr_duty;
    duty_d     = wr_duty ? writedata[7:0]
               : (step && state_q == FADE_UP) ? duty_up
               : (step && state_q == FADE_DOWN) ? duty_dn
               : duty_q;
    led_d      = !en ? 8'd0 : (duty_q == 8'hFF) ? led_in : led_in & {8{pwm_cnt < duty_q}};
  end
  always_comb begin
    state_d = state_q;
    if (!fade_on) state_d = FADE_IDLE;
    else begin
      case (state_q)
        FADE_IDLE: state_d = FADE_UP;
        FADE_UP:   if (step && duty_up == 8'hFF) state_d = FADE_DOWN;
        FADE_DOWN: if (step && duty_dn == 8'h00) state_d = FADE_UP;
        default:   state_d = FADE_IDLE;
      endcase
    end
  end
  assign fade_dir = (state_q == FADE_DOWN);
  assign led_out  = led_q;
  assign readdata = (address == ADDR_CTRL) ? {30'd0, ctrl_q}
                  : (address == ADDR_DUTY) ? {24'd0, duty_q}
                  : (address == ADDR_PRESCALE) ? {16'd0, prescale_q}
                  : {23'd0, fade_dir, pwm_cnt};
  waves_led_pwm_timebase u_tb (
    .clk        (clk),
    .reset      (reset),
    .enable     (en),
    .clear      (wr_presc),
    .prescale   (prescale_q),
    .tick       (tick),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      duty_q     <= DUTY_RST;
      prescale_q <= '0;
      state_q    <= FADE_IDLE;
      led_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      duty_q     <= duty_d;
      prescale_q <= prescale_d;
      state_q    <= state_d;
      led_q      <= led_d;
    end
  end
endmodule

// File: tb/tb_waves_led_pwm.sv
// tb_waves_led_pwm: directed table and sequence checks for waves_led_pwm
module tb_waves_led_pwm;
  import waves_led_pwm_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  address = '0;
  logic        chipselect = 0;
  logic        write_n = 1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  led_in = '0;
  logic [7:0]  led_out;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    logic [1:0] ctrl;
    logic [7:0] duty;
    logic [7:0] led;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];
  waves_led_pwm dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    @(negedge clk);
    chipselect = 0;
    write_n = 1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask
  task automatic wait_duty(input logic [7:0] old, output logic [7:0] nv, output logic dir);
    logic [31:0] r;
    int n;
    n = 0;
    nv = old;
    while (nv == old && n < 400) begin
      @(negedge clk);
      rd(ADDR_DUTY, r);
      nv = r[7:0];
      n++;
    end
    rd(ADDR_STATUS, r);
    dir = r[8];
    if (nv == old) begin
      checks++;
      errors++;
      $display("FAIL wait_duty: timeout, duty stuck at %0h", old);
    end
  endtask
  task automatic wait_pwm(input logic [7:0] target, input string nm);
    logic [31:0] r;
    int n;
    n = 0;
    rd(ADDR_STATUS, r);
    while (r[7:0] != target && n < 300) begin
      @(negedge clk);
      rd(ADDR_STATUS, r);
      n++;
    end
    chk(nm, {24'd0, r[7:0]}, {24'd0, target});
  endtask
  initial begin
    logic [31:0] r;
    logic [7:0]  base, nv;
    logic        dir;
    int          hi, lo;
    vecs[0] = '{2'b01, 8'hFF, 8'hA5, 8'hA5};
    vecs[1] = '{2'b01, 8'h40, 8'hFF, 8'hFF};
    vecs[2] = '{2'b01, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{2'b00, 8'hFF, 8'h5A, 8'h00};
    vecs[4] = '{2'b01, 8'h01, 8'h3C, 8'h3C};
    vecs[5] = '{2'b01, 8'hFF, 8'h00, 8'h00};
    vecs[6] = '{2'b00, 8'h40, 8'hFF, 8'h00};
    vecs[7] = '{2'b01, 8'h80, 8'hC3, 8'hC3};
    repeat (3) @(negedge clk);
    reset = 0;
    rd(ADDR_CTRL, r);     chk("rst_ctrl", r, 32'h0);
    rd(ADDR_DUTY, r);     chk("rst_duty", r, 32'hFF);
    rd(ADDR_PRESCALE, r); chk("rst_prescale", r, 32'h0);
    rd(ADDR_STATUS, r);   chk("rst_status", r, 32'h0);
    chk("rst_led", {24'd0, led_out}, 32'h0);
    bus_write(ADDR_PRESCALE, 32'hFFFF);
    for (int i = 0; i < 8; i++) begin
      bus_write(ADDR_CTRL, {30'd0, vecs[i].ctrl});
      bus_write(ADDR_DUTY, {24'd0, vecs[i].duty});
      led_in = vecs[i].led;
      @(negedge clk);
      chk("vec_led", {24'd0, led_out}, {24'd0, vecs[i].exp});
      rd(ADDR_DUTY, r);   chk("vec_duty", r, {24'd0, vecs[i].duty});
      rd(ADDR_STATUS, r); chk("vec_status", r, 32'h0);
    end
    led_in = 8'hFF;
    bus_write(ADDR_PRESCALE, 32'h0);
    bus_write(ADDR_DUTY, 32'h40);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out == 8'hFF) hi++;
      if (led_out == 8'h00) lo++;
    end
    chk("pwm_hi_count", hi, 64);
    chk("pwm_lo_count", lo, 192);
    bus_write(ADDR_PRESCALE, 32'd3);
    rd(ADDR_STATUS, r);
    base = r[7:0];
    repeat (3) @(negedge clk);
    rd(ADDR_STATUS, r); chk("presc3_hold", {24'd0, r[7:0]}, {24'd0, base});
    @(negedge clk);
    rd(ADDR_STATUS, r); chk("presc3_tick", {24'd0, r[7:0]}, {24'd0, base + 8'd1});
    bus_write(ADDR_PRESCALE, 32'd1);
    rd(ADDR_STATUS, r); chk("presc1_wr", {24'd0, r[7:0]}, {24'd0, base + 8'd1});
    @(negedge clk);
    rd(ADDR_STATUS, r); chk("presc1_c1", {24'd0, r[7:0]}, {24'd0, base + 8'd1});
    @(negedge clk);
    rd(ADDR_STATUS, r); chk("presc1_c2", {24'd0, r[7:0]}, {24'd0, base + 8'd2});
    repeat (2) @(negedge clk);
    rd(ADDR_STATUS, r); chk("presc1_c4", {24'd0, r[7:0]}, {24'd0, base + 8'd3});
    bus_write(ADDR_PRESCALE, 32'h0);
    bus_write(ADDR_DUTY, 32'hFD);
    bus_write(ADDR_CTRL, 32'h3);
    wait_duty(8'hFD, nv, dir); chk("fade_fe", {23'd0, dir, nv}, {23'd0, 1'b0, 8'hFE});
    wait_duty(8'hFE, nv, dir); chk("fade_ff", {23'd0, dir, nv}, {23'd0, 1'b1, 8'hFF});
    wait_duty(8'hFF, nv, dir); chk("fade_fe_down", {23'd0, dir, nv}, {23'd0, 1'b1, 8'hFE});
    bus_write(ADDR_DUTY, 32'h01);
    wait_duty(8'h01, nv, dir); chk("fade_00", {23'd0, dir, nv}, {23'd0, 1'b0, 8'h00});
    wait_duty(8'h00, nv, dir); chk("fade_01_up", {23'd0, dir, nv}, {23'd0, 1'b0, 8'h01});
    wait_pwm(8'hFE, "sync_fe");
    bus_write(ADDR_DUTY, 32'h10);
    rd(ADDR_DUTY, r);   chk("pe_write_duty", r, 32'h10);
    rd(ADDR_STATUS, r); chk("pe_write_dir", {31'd0, r[8]}, 32'h0);
    wait_duty(8'h10, nv, dir); chk("pe_write_next", {23'd0, dir, nv}, {23'd0, 1'b0, 8'h11});
    wait_pwm(8'h05, "sync_05");
    chk("led_before_dis", {24'd0, led_out}, 32'hFF);
    bus_write(ADDR_CTRL, 32'h0);
    chk("dis_led", {24'd0, led_out}, 32'h0);
    rd(ADDR_STATUS, r); chk("dis_status", r, 32'h0);
    rd(ADDR_DUTY, r);   chk("dis_duty_frozen", r, 32'h11);
    bus_write(ADDR_DUTY, 32'hFE);
    bus_write(ADDR_CTRL, 32'h3);
    wait_duty(8'hFE, nv, dir); chk("pre_rst_fade", {23'd0, dir, nv}, {23'd0, 1'b1, 8'hFF});
    bus_write(ADDR_PRESCALE, 32'd7);
    chk("pre_rst_led", {24'd0, led_out}, 32'hFF);
    @(negedge clk);
    reset = 1;
    address = ADDR_DUTY;
    writedata = 32'h33;
    chipselect = 1;
    write_n = 0;
    @(negedge clk);
    reset = 0;
    chipselect = 0;
    write_n = 1;
    rd(ADDR_CTRL, r);     chk("mid_rst_ctrl", r, 32'h0);
    rd(ADDR_DUTY, r);     chk("mid_rst_duty", r, 32'hFF);
    rd(ADDR_PRESCALE, r); chk("mid_rst_prescale", r, 32'h0);
    rd(ADDR_STATUS, r);   chk("mid_rst_status", r, 32'h0);
    chk("mid_rst_led", {24'd0, led_out}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
